// File: rtl/univ_shreg_ar_if.sv
// univ_shreg_ar_if: control/data bundle for the universal shift register.
// Ports (master drives, slave receives):
//   en, mode[1:0], rot, sin_r, sin_l, d[WIDTH-1:0]   -> register
//   q[WIDTH-1:0], sout_r, sout_l, cnt[CW-1:0], done  <- register
interface univ_shreg_ar_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);
    logic             en;
    logic [1:0]       mode;
    logic             rot;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             done;
    modport master (output en, mode, rot, sin_r, sin_l, d,
                    input  q, sout_r, sout_l, cnt, done);
    modport slave  (input  en, mode, rot, sin_r, sin_l, d,
                    output q, sout_r, sout_l, cnt, done);
endinterface

// File: rtl/univ_shreg_ar.sv
// univ_shreg_ar: universal shift register (hold / shift right / shift left /
// parallel load) with optional rotate, saturating shift counter and done flag.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (q=RESET_VAL, cnt=0, done=0)
//   bus   - univ_shreg_ar_if.slave: en, mode, rot, sin_r, sin_l, d in;
//           q, sout_r (=q[0]), sout_l (=q[WIDTH-1]), cnt, done out
module univ_shreg_ar #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               reset,
    univ_shreg_ar_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_shift;
    logic [CW-1:0]    cnt;
    logic             done;
    logic             shift;
    assign shift = bus.mode == 2'b01 || bus.mode == 2'b10;
    always_comb begin
        q_shift = bus.mode == 2'b01
                ? {bus.rot ? q[0] : bus.sin_r, q[WIDTH-1:1]}
                : {q[WIDTH-2:0], bus.rot ? q[WIDTH-1] : bus.sin_l};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else if (bus.en) begin
            if (bus.mode == 2'b11) begin
                q    <= bus.d;
                cnt  <= '0;
                done <= 1'b0;
            end else if (shift) begin
                q <= q_shift;
                // q keeps shifting after saturation; only cnt/done freeze
                if (cnt != CW'(WIDTH)) cnt <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) done <= 1'b1;
            end
        end
    end
    assign bus.q      = q;
    assign bus.cnt    = cnt;
    assign bus.done   = done;
    assign bus.sout_r = q[0];
    assign bus.sout_l = q[WIDTH-1];
endmodule

// File: tb/tb_univ_shreg_ar.sv
// tb_univ_shreg_ar: self-checking bench for univ_shreg_ar (WIDTH=8, RESET_VAL=0).
module tb_univ_shreg_ar;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_q = 0;
    int   m_cnt = 0;
    bit   m_done = 1'b0;

    univ_shreg_ar_if #(.WIDTH(8)) bus ();
    univ_shreg_ar #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 64'(bus.q), 64'(m_q));
        chk({tag, ".cnt"}, 64'(bus.cnt), 64'(m_cnt));
        chk({tag, ".done"}, 64'(bus.done), 64'(m_done));
        chk({tag, ".sout_r"}, 64'(bus.sout_r), 64'(m_q % 2));
        chk({tag, ".sout_l"}, 64'(bus.sout_l), 64'(m_q / 128));
    endtask

    task automatic model_reset();
        m_q = 0;
        m_cnt = 0;
        m_done = 1'b0;
    endtask

    // Reference behaviour from the register's rules, using integer arithmetic.
    task automatic model_edge();
        int inbit;
        if (!reset || !bus.en) return;
        if (bus.mode == 2'd3) begin
            m_q = int'(bus.d);
            m_cnt = 0;
            m_done = 1'b0;
        end else if (bus.mode != 2'd0) begin
            if (bus.mode == 2'd1) begin
                inbit = bus.rot ? m_q % 2 : int'(bus.sin_r);
                m_q = m_q / 2 + inbit * 128;
            end else begin
                inbit = bus.rot ? m_q / 128 : int'(bus.sin_l);
                m_q = (m_q * 2) % 256 + inbit;
            end
            if (m_cnt < 8) m_cnt++;
            m_done = (m_cnt == 8);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit e, input logic [1:0] m, input bit r,
                         input bit sr, input bit sl, input logic [7:0] dd);
        bus.en = e; bus.mode = m; bus.rot = r; bus.sin_r = sr; bus.sin_l = sl; bus.d = dd;
    endtask

    initial begin
        drive(0, 2'd0, 0, 0, 0, 8'h00);
        #2;
        check_all("reset_init");
        @(negedge clk);
        reset = 1'b1;
        drive(1, 2'd3, 0, 0, 0, 8'hA5);
        step("load_a5");
        chk("load_a5.q_const", 64'(bus.q), 64'hA5);
        drive(1, 2'd1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 8; i++) step("shr_fill");
        chk("shr8.q_const", 64'(bus.q), 64'hFF);
        chk("shr8.cnt_const", 64'(bus.cnt), 64'd8);
        chk("shr8.done_const", 64'(bus.done), 64'd1);
        step("shr9_sat");
        chk("shr9.cnt_const", 64'(bus.cnt), 64'd8);
        drive(1, 2'd3, 1, 0, 0, 8'h81);
        step("load_81_rot_ignored");
        drive(1, 2'd2, 1, 0, 0, 8'h00);
        step("rotl1");
        chk("rotl1.q_const", 64'(bus.q), 64'h03);
        for (int i = 0; i < 7; i++) step("rotl");
        chk("rotl8.q_const", 64'(bus.q), 64'h81);
        chk("rotl8.done_const", 64'(bus.done), 64'd1);
        drive(0, 2'd1, 0, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) step("en0_hold");
        chk("en0.q_const", 64'(bus.q), 64'h81);
        drive(1, 2'd0, 1, 1, 1, 8'h5A);
        step("mode00_hold");
        drive(1, 2'd3, 0, 0, 0, 8'hC3);
        step("load_c3");
        drive(1, 2'd1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step("shr4");
        chk("shr4.cnt_const", 64'(bus.cnt), 64'd4);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_reset.q_const", 64'(bus.q), 64'h00);
        step("reset_held_edge");
        reset = 1'b1;
        drive(1, 2'd3, 0, 0, 0, 8'h3C);
        step("load_3c");
        chk("load_3c.q_const", 64'(bus.q), 64'h3C);
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 29) != 0);
            drive(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 1'($urandom), 8'($urandom));
            if (!reset) begin
                model_reset();
                #1;
                check_all("rnd_async");
            end
            step("rnd");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/univ_shreg_ar.md
UNIV_SHREG_AR -- requirements
Module: univ_shreg_ar

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, meaning the WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port en, input, 1 bit: operation enable; when 0, all state holds.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port rot, input, 1 bit: 1 = rotate on shift; 0 = fill from the serial inputs.
REQ-008 The block SHALL have port sin_r, input, 1 bit: serial bit entering at q[WIDTH-1] on shift right.
REQ-009 The block SHALL have port sin_l, input, 1 bit: serial bit entering at q[0] on shift left.
REQ-010 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-011 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-012 The block SHALL have port sout_r, output, 1 bit: combinational copy of q[0].
REQ-013 The block SHALL have port sout_l, output, 1 bit: combinational copy of q[WIDTH-1].
REQ-014 The block SHALL have port cnt, output, $clog2(WIDTH+1) bits: shifts since the last load, saturating at WIDTH.
REQ-015 The block SHALL have port done, output, 1 bit: registered flag, 1 when cnt == WIDTH.

Function
REQ-016 When en=0 or mode=00, q, cnt and done SHALL hold their values on the clock edge.
REQ-017 Shift right, en=1 and mode=01, SHALL set q <= {rot ? q[0] : sin_r, q[WIDTH-1:1]} in one cycle.
REQ-018 Shift left, en=1 and mode=10, SHALL set q <= {q[WIDTH-2:0], rot ? q[WIDTH-1] : sin_l} in one cycle.
REQ-019 Parallel load, en=1 and mode=11, SHALL set q <= d and cnt <= 0, and SHALL clear done on the same edge.
REQ-020 Each enabled shift SHALL increment cnt by 1 while cnt < WIDTH; at WIDTH, cnt SHALL saturate and SHALL NOT wrap.
REQ-021 done SHALL assert on the edge where cnt becomes WIDTH and SHALL stay 1 until a load or reset.
REQ-022 Shifting SHALL continue to modify q after saturation; only cnt and done freeze.
REQ-023 Latency SHALL be one clock from the input sample to updated q, cnt and done; sout_r and sout_l SHALL follow q with zero latency.
REQ-024 rot SHALL be sampled only during shift modes and SHALL have no effect in hold or load.
REQ-025 Mode changes between consecutive cycles SHALL take effect immediately, with no pipeline bubble.

Reset
REQ-026 reset=0 SHALL immediately, without a clock, force q=RESET_VAL, cnt=0 and done=0.
REQ-027 While reset=0, clock edges SHALL have no effect.
REQ-028 Reset asserted mid-shift sequence SHALL discard the partial count; the first edge after reset deasserts SHALL behave as from power-up.
REQ-029 Reset deassertion SHALL take effect at the next rising clk edge; deassertion coincident with an edge SHALL NOT corrupt state.

Verification (WIDTH=8, RESET_VAL=0)
REQ-030 The bench SHALL cover: load d=8'hA5, mode=11 -> next cycle q=A5, cnt=0, done=0.
REQ-031 The bench SHALL cover: from q=A5, shift right with rot=0 and sin_r=1 for 8 cycles -> q=FF, cnt=8, done=1 on the 8th edge; a 9th shift leaves cnt=8.
REQ-032 The bench SHALL cover: from q=81, shift left with rot=1 for 1 cycle -> q=03; 8 rotates total -> q=81 restored, done=1.
REQ-033 The bench SHALL cover: en=0 with mode=01 for 3 cycles -> q and cnt unchanged.
REQ-034 The bench SHALL cover: after 4 shifts (cnt=4), drive reset=0 between edges -> q=00, cnt=0, done=0 before the next edge; release, then load 3C -> q=3C.
REQ-035 The bench SHALL cover: randomised mode, en, rot and serial inputs, plus random reset pulses, over 500 cycles -> q, cnt and done match a cycle-accurate reference model every cycle.
